alarm_ctrl: RTL and testbench

Alarm controller sitting directly downstream of the alarm-time setting stage. It compares the running BCD time against the stored alarm time, raises the alarm once per matching minute, and drives a 1 Hz-gated buzzer. It also handles snooze and stop pushbuttons, enforcing a ring timeout and a snooze limit.

---
 rtl/alarm_pkg.sv | 11 +
 rtl/alarm_ctrl_btn_sync_edge.sv | 24 ++
 rtl/alarm_ctrl.sv | 126 ++++++++++++
 tb/tb_alarm_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encoding and field widths.
package alarm_pkg;
    localparam int BCD_W     = 4;
    localparam int SEC_CNT_W = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;
endpackage

// File: rtl/alarm_ctrl_btn_sync_edge.sv
// Raw active-low pushbutton: 2-flop synchroniser, then a registered falling-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic fall
);
    logic sync1, sync2, sync3;

    // Reset to released (high) so deasserting reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            sync3 <= sync2;
            fall  <= sync3 & ~sync2;
        end
    end
endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: BCD time match, ring/snooze FSM with ring timeout and snooze limit,
// 1 Hz-gated buzzer. All outputs come straight from flops.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int SNOOZE_MAX     = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_1hz,
    input  logic [BCD_W-1:0] th1,
    input  logic [BCD_W-1:0] th0,
    input  logic [BCD_W-1:0] tm1,
    input  logic [BCD_W-1:0] tm0,
    input  logic [BCD_W-1:0] ts1,
    input  logic [BCD_W-1:0] ts0,
    input  logic [BCD_W-1:0] ah1,
    input  logic [BCD_W-1:0] ah0,
    input  logic [BCD_W-1:0] am1,
    input  logic [BCD_W-1:0] am0,
    input  logic             set_mode,
    input  logic             alarm_en,
    input  logic             push_snooze,
    input  logic             push_stop,
    output logic             buzzer,
    output logic             ringing,
    output logic             snoozing,
    output logic [3:0]       snooze_cnt
);
    localparam logic [SEC_CNT_W-1:0] RING_LAST   = SEC_CNT_W'(RING_SECONDS - 1);
    localparam logic [SEC_CNT_W-1:0] SNOOZE_LAST = SEC_CNT_W'(SNOOZE_SECONDS - 1);
    localparam logic [3:0]           SNZ_LIMIT   = 4'(SNOOZE_MAX);

    state_t               state, state_n;
    logic [SEC_CNT_W-1:0] sec_cnt, sec_n;
    logic                 beep, beep_n;
    logic [3:0]           scnt_n;
    logic                 hit, hit_q, trigger;
    logic                 snz_ev, stp_ev;

    btn_sync_edge u_snz (.clk(clk), .reset_n(reset_n), .btn(push_snooze), .fall(snz_ev));
    btn_sync_edge u_stp (.clk(clk), .reset_n(reset_n), .btn(push_stop),   .fall(stp_ev));

    // hit_q holding high across the whole matching second gives one trigger per minute.
    assign hit = alarm_en & ~set_mode
               & ({th1, th0, tm1, tm0} == {ah1, ah0, am1, am0})
               & ({ts1, ts0} == '0);
    assign trigger = hit & ~hit_q;

    always_comb begin
        state_n = state;
        sec_n   = sec_cnt;
        beep_n  = beep;
        scnt_n  = snooze_cnt;
        if (!alarm_en) begin
            state_n = IDLE;
            sec_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state_n = RINGING;
                        sec_n   = '0;
                        beep_n  = 1'b1;
                        scnt_n  = '0;
                    end
                end
                RINGING: begin
                    if (stp_ev) begin
                        state_n = IDLE;
                    end else if (snz_ev && (snooze_cnt < SNZ_LIMIT)) begin
                        state_n = SNOOZE;
                        scnt_n  = snooze_cnt + 4'd1;
                        sec_n   = '0;
                    end else if (tick_1hz) begin
                        if (sec_cnt == RING_LAST) begin
                            state_n = IDLE;
                        end else begin
                            sec_n  = sec_cnt + 1'b1;
                            beep_n = ~beep;
                        end
                    end
                end
                SNOOZE: begin
                    if (stp_ev) begin
                        state_n = IDLE;
                    end else if (tick_1hz) begin
                        if (sec_cnt == SNOOZE_LAST) begin
                            state_n = RINGING;
                            sec_n   = '0;
                            beep_n  = 1'b1;
                        end else begin
                            sec_n = sec_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sec_cnt    <= '0;
            beep       <= 1'b0;
            snooze_cnt <= '0;
            hit_q      <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            buzzer     <= 1'b0;
        end else begin
            state      <= state_n;
            sec_cnt    <= sec_n;
            beep       <= beep_n;
            snooze_cnt <= scnt_n;
            hit_q      <= hit;
            ringing    <= (state_n == RINGING);
            snoozing   <= (state_n == SNOOZE);
            buzzer     <= (state_n == RINGING) & beep_n;
        end
    end
endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with default parameters (60 / 300 / 3).
module tb_alarm_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [3:0] th1, th0, tm1, tm0, ts1, ts0;
    logic [3:0] ah1, ah0, am1, am0;
    logic       set_mode = 1'b0;
    logic       alarm_en = 1'b1;
    logic       push_snooze = 1'b1;
    logic       push_stop = 1'b1;
    logic       buzzer, ringing, snoozing;
    logic [3:0] snooze_cnt;

    int total = 0;
    int bad = 0;

    alarm_ctrl dut (
        .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz),
        .th1(th1), .th0(th0), .tm1(tm1), .tm0(tm0), .ts1(ts1), .ts0(ts0),
        .ah1(ah1), .ah0(ah0), .am1(am1), .am0(am0),
        .set_mode(set_mode), .alarm_en(alarm_en),
        .push_snooze(push_snooze), .push_stop(push_stop),
        .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_time(input logic [3:0] h1, h0, m1, m0, s1, s0);
        th1 = h1; th0 = h0; tm1 = m1; tm0 = m0; ts1 = s1; ts0 = s0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            step();
        end
    endtask

    // Hold the button(s) low for 4 clocks (the state change lands on the 4th edge), then release.
    task automatic press(input logic snz, input logic stp);
        push_snooze = ~snz;
        push_stop   = ~stp;
        repeat (4) step();
    endtask

    task automatic release_btns();
        push_snooze = 1'b1;
        push_stop   = 1'b1;
        repeat (4) step();
    endtask

    task automatic arm_and_trigger();
        set_time(0, 7, 2, 9, 5, 9);
        step();
        set_time(0, 7, 3, 0, 0, 0);
        step();
    endtask

    initial begin
        ah1 = 4'd0; ah0 = 4'd7; am1 = 4'd3; am0 = 4'd0;
        set_time(0, 7, 2, 9, 5, 9);
        #12;
        chk("rst_ringing", {3'b0, ringing}, 4'd0);
        chk("rst_snoozing", {3'b0, snoozing}, 4'd0);
        chk("rst_buzzer", {3'b0, buzzer}, 4'd0);
        chk("rst_snooze_cnt", snooze_cnt, 4'd0);
        reset_n = 1'b1;
        repeat (3) step();

        // 07:29:59 -> 07:30:00: ringing one clock after the match.
        set_time(0, 7, 3, 0, 0, 0);
        #1;
        chk("pre_match_ringing", {3'b0, ringing}, 4'd0);
        step();
        chk("match_ringing", {3'b0, ringing}, 4'd1);
        chk("match_buzzer", {3'b0, buzzer}, 4'd1);
        ticks(1);
        chk("beep_t1", {3'b0, buzzer}, 4'd0);
        ticks(1);
        chk("beep_t2", {3'b0, buzzer}, 4'd1);
        ticks(57);
        chk("ring_t59_ringing", {3'b0, ringing}, 4'd1);
        chk("ring_t59_buzzer", {3'b0, buzzer}, 4'd0);
        ticks(1);
        chk("ring_t60_ringing", {3'b0, ringing}, 4'd0);
        chk("ring_t60_buzzer", {3'b0, buzzer}, 4'd0);
        ticks(3);
        chk("no_retrigger_same_min", {3'b0, ringing}, 4'd0);

        // set_mode=1 or alarm_en=0 suppress the match.
        set_time(0, 7, 2, 9, 5, 9);
        set_mode = 1'b1;
        step();
        set_time(0, 7, 3, 0, 0, 0);
        repeat (2) step();
        chk("setmode_no_trigger", {3'b0, ringing}, 4'd0);
        set_time(0, 7, 2, 9, 5, 9);
        step();
        set_mode = 1'b0;
        alarm_en = 1'b0;
        step();
        set_time(0, 7, 3, 0, 0, 0);
        repeat (2) step();
        chk("disabled_no_trigger", {3'b0, ringing}, 4'd0);
        alarm_en = 1'b1;

        // Three snoozes, each returning to ringing on the 300th tick.
        arm_and_trigger();
        chk("trig2_ringing", {3'b0, ringing}, 4'd1);
        for (int k = 1; k <= 3; k++) begin
            press(1'b1, 1'b0);
            chk($sformatf("snz%0d_snoozing", k), {3'b0, snoozing}, 4'd1);
            chk($sformatf("snz%0d_ringing", k), {3'b0, ringing}, 4'd0);
            chk($sformatf("snz%0d_cnt", k), snooze_cnt, 4'(k));
            release_btns();
            ticks(299);
            chk($sformatf("snz%0d_t299", k), {3'b0, snoozing}, 4'd1);
            ticks(1);
            chk($sformatf("snz%0d_t300_ringing", k), {3'b0, ringing}, 4'd1);
            chk($sformatf("snz%0d_t300_buzzer", k), {3'b0, buzzer}, 4'd1);
        end
        press(1'b1, 1'b0);
        chk("snz4_ignored_ringing", {3'b0, ringing}, 4'd1);
        chk("snz4_ignored_snoozing", {3'b0, snoozing}, 4'd0);
        chk("snz4_cnt", snooze_cnt, 4'd3);
        release_btns();

        // Snooze and stop together: stop wins; snooze_cnt held in IDLE.
        press(1'b1, 1'b1);
        chk("both_ringing", {3'b0, ringing}, 4'd0);
        chk("both_snoozing", {3'b0, snoozing}, 4'd0);
        chk("idle_cnt_held", snooze_cnt, 4'd3);
        release_btns();

        // New event clears the count; stop during snooze.
        arm_and_trigger();
        chk("trig3_ringing", {3'b0, ringing}, 4'd1);
        chk("trig3_cnt_clr", snooze_cnt, 4'd0);
        press(1'b1, 1'b0);
        release_btns();
        chk("trig3_snoozing", {3'b0, snoozing}, 4'd1);
        press(1'b0, 1'b1);
        chk("stop_snz_snoozing", {3'b0, snoozing}, 4'd0);
        chk("stop_snz_ringing", {3'b0, ringing}, 4'd0);
        chk("stop_snz_buzzer", {3'b0, buzzer}, 4'd0);
        release_btns();

        // alarm_en drop forces IDLE on the next edge.
        arm_and_trigger();
        chk("trig4_ringing", {3'b0, ringing}, 4'd1);
        alarm_en = 1'b0;
        step();
        chk("en_off_ringing", {3'b0, ringing}, 4'd0);
        chk("en_off_buzzer", {3'b0, buzzer}, 4'd0);
        alarm_en = 1'b1;

        // Asynchronous reset mid-ring; event lost.
        arm_and_trigger();
        chk("trig5_ringing", {3'b0, ringing}, 4'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_ringing", {3'b0, ringing}, 4'd0);
        chk("async_rst_buzzer", {3'b0, buzzer}, 4'd0);
        set_time(0, 7, 3, 0, 0, 1);
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("post_rst_no_ring", {3'b0, ringing}, 4'd0);
        arm_and_trigger();
        chk("next_match_ringing", {3'b0, ringing}, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
